// File: rtl/wb_stage_skid_pkg.sv
// Shared widths, writeback constants and skid-register state encodings for the
// memory-to-writeback stage.
package wb_stage_skid_pkg;

  localparam int   RADDR_WIDTH   = 5;
  localparam int   RDATA_WIDTH   = 32;
  localparam int   ZERO_REG      = 0;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic ZERO          = 1'b0;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/wb_stage_skid_pipe_skid.sv
// Generic 2-entry skid register: 1-cycle latency, registered outputs.
// in_ready_o is a flop (low only when both entries are held); flush empties it next cycle.
module wb_stage_skid_pipe_skid
  import wb_stage_skid_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   occupancy_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         in_rdy_q;
  logic         accept, drain;
  logic         load_main_in, load_main_skid, load_skid;

  assign out_valid_o = (state_q != SKID_EMPTY);
  assign in_ready_o  = in_rdy_q;
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;

  assign accept = in_valid_i & in_rdy_q & ~flush_i;
  assign drain  = out_valid_o & out_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = SKID_FULL;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (drain) begin
          load_main_skid = 1'b1;
          state_d        = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    // Flush wins; the skid entry is dropped rather than promoted.
    if (flush_i) begin
      state_d        = SKID_EMPTY;
      load_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SKID_EMPTY;
      in_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_rdy_q <= (state_d != SKID_FULL);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data_i;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data_i;
      end
    end
  end

endmodule

// File: rtl/wb_stage_skid.sv
// Memory-to-writeback stage register: 1-cycle latency, 1 cmd/cycle, 2-entry skid absorbs
// out_ready_i stalls so in_ready_o is registered; writes to the zero register are disabled at capture.
module wb_stage_skid
  import wb_stage_skid_pkg::*;
#(
  parameter int            AW          = RADDR_WIDTH,
  parameter int            DW          = RDATA_WIDTH,
  parameter bit            SUPPRESS_X0 = 1'b1,
  parameter logic [AW-1:0] ZERO_ADDR   = AW'(ZERO_REG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [AW-1:0] reg_waddr_i,
  input  logic          reg_we_i,
  input  logic [DW-1:0] reg_wdata_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] reg_waddr_o,
  output logic          reg_we_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic [1:0]    occupancy_o
);

  localparam int PW = AW + 1 + DW;

  logic [PW-1:0] pkt_in, pkt_out;
  logic          we_cap, held_we;

  // Command still occupies a slot and handshakes; only its write is disabled.
  assign we_cap = (SUPPRESS_X0 && (reg_waddr_i == ZERO_ADDR)) ? WRITE_DISABLE : reg_we_i;
  assign pkt_in = {reg_waddr_i, we_cap, reg_wdata_i};

  wb_stage_skid_pipe_skid #(
    .W (PW)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (pkt_in),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (pkt_out),
    .occupancy_o (occupancy_o)
  );

  assign {reg_waddr_o, held_we, reg_wdata_o} = pkt_out;
  assign reg_we_o = out_valid_o & held_we;

endmodule

// File: tb/tb_wb_stage_skid.sv
// Directed and randomised checks of wb_stage_skid against hand-computed values and a queue scoreboard.
module tb_wb_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_vld, in_rdy, in_rdy_x;
  logic [4:0]  waddr;
  logic        we;
  logic [31:0] wdata;
  logic        out_vld, out_vld_x;
  logic        out_rdy;
  logic [4:0]  o_waddr, o_waddr_x;
  logic        o_we, o_we_x;
  logic [31:0] o_wdata, o_wdata_x;
  logic [1:0]  occ, occ_x;

  int n_cmp = 0;
  int n_err = 0;

  logic [37:0] sb_q[$];
  logic [37:0] exp_pkt;
  logic        stall_prev;
  logic [4:0]  p_addr;
  logic        p_we;
  logic [31:0] p_data;

  always #5 clk = ~clk;

  wb_stage_skid dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_vld),
    .in_ready_o  (in_rdy),
    .reg_waddr_i (waddr),
    .reg_we_i    (we),
    .reg_wdata_i (wdata),
    .out_valid_o (out_vld),
    .out_ready_i (out_rdy),
    .reg_waddr_o (o_waddr),
    .reg_we_o    (o_we),
    .reg_wdata_o (o_wdata),
    .occupancy_o (occ)
  );

  wb_stage_skid #(.SUPPRESS_X0(1'b0)) dut_nosup (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_vld),
    .in_ready_o  (in_rdy_x),
    .reg_waddr_i (waddr),
    .reg_we_i    (we),
    .reg_wdata_i (wdata),
    .out_valid_o (out_vld_x),
    .out_ready_i (out_rdy),
    .reg_waddr_o (o_waddr_x),
    .reg_we_o    (o_we_x),
    .reg_wdata_o (o_wdata_x),
    .occupancy_o (occ_x)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic w, input logic [31:0] d);
    in_vld = v;
    waddr  = a;
    we     = w;
    wdata  = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    out_rdy = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0);

    // Reset state
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_we", o_we, 0);
    chk("rst_occ", occ, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_waddr", o_waddr, 0);
    chk("rst_wdata", o_wdata, 0);
    rst_n = 1'b1;
    step();

    // Streaming at full rate
    out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 1'b1, 32'h100 + 32'(i));
      step();
      chk("strm_vld", out_vld, 1);
      chk("strm_waddr", o_waddr, i);
      chk("strm_wdata", o_wdata, 32'h100 + 32'(i));
      chk("strm_we", o_we, 1);
      chk("strm_occ", occ, 1);
      chk("strm_in_rdy", in_rdy, 1);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    step();
    chk("strm_end_vld", out_vld, 0);
    chk("strm_end_occ", occ, 0);

    // Back-pressure fills the skid entry
    out_rdy = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 32'hAAAA);
    step();
    chk("bp_a_occ", occ, 1);
    chk("bp_a_in_rdy", in_rdy, 1);
    drive(1'b1, 5'd4, 1'b1, 32'hBBBB);
    step();
    chk("bp_full_occ", occ, 2);
    chk("bp_full_in_rdy", in_rdy, 0);
    chk("bp_full_waddr", o_waddr, 3);
    chk("bp_full_wdata", o_wdata, 32'hAAAA);
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    step();
    chk("bp_hold_waddr", o_waddr, 3);
    chk("bp_hold_wdata", o_wdata, 32'hAAAA);
    chk("bp_hold_we", o_we, 1);
    chk("bp_hold_occ", occ, 2);
    out_rdy = 1'b1;
    step();
    chk("bp_b_waddr", o_waddr, 4);
    chk("bp_b_wdata", o_wdata, 32'hBBBB);
    chk("bp_b_occ", occ, 1);
    chk("bp_b_in_rdy", in_rdy, 1);
    step();
    chk("bp_done_vld", out_vld, 0);

    // Zero-register suppression and we=0 beats
    drive(1'b1, 5'd0, 1'b1, 32'hDEAD);
    step();
    chk("x0_vld", out_vld, 1);
    chk("x0_we_sup", o_we, 0);
    chk("x0_wdata", o_wdata, 32'hDEAD);
    chk("x0_we_nosup", o_we_x, 1);
    drive(1'b1, 5'd5, 1'b0, 32'h5555);
    step();
    chk("we0_vld", out_vld, 1);
    chk("we0_we", o_we, 0);
    chk("we0_waddr", o_waddr, 5);
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    step();

    // Flush from FULL with a live input beat
    out_rdy = 1'b0;
    drive(1'b1, 5'd6, 1'b1, 32'hCCCC);
    step();
    drive(1'b1, 5'd7, 1'b1, 32'hDDDD);
    step();
    chk("fl_pre_occ", occ, 2);
    drive(1'b1, 5'd8, 1'b1, 32'hEEEE);
    flush = 1'b1;
    step();
    chk("fl_occ", occ, 0);
    chk("fl_vld", out_vld, 0);
    chk("fl_in_rdy", in_rdy, 1);
    chk("fl_we", o_we, 0);
    flush   = 1'b0;
    out_rdy = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    step();
    chk("fl_after_vld", out_vld, 0);
    chk("fl_after_occ", occ, 0);

    // Asynchronous reset mid-cycle with two entries held
    out_rdy = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 32'h9999);
    step();
    drive(1'b1, 5'd10, 1'b1, 32'hAAA0);
    step();
    chk("ar_pre_occ", occ, 2);
    drive(1'b0, 5'd0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", out_vld, 0);
    chk("ar_we", o_we, 0);
    chk("ar_occ", occ, 0);
    chk("ar_in_rdy", in_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised traffic against a queue scoreboard
    stall_prev = 1'b0;
    p_addr     = '0;
    p_we       = 1'b0;
    p_data     = '0;
    for (int c = 0; c < 1005; c++) begin
      if (stall_prev) begin
        chk("rnd_stall_waddr", o_waddr, p_addr);
        chk("rnd_stall_we", o_we, p_we);
        chk("rnd_stall_wdata", o_wdata, p_data);
      end
      chk("rnd_occ", occ, sb_q.size());
      chk("rnd_in_rdy", in_rdy, sb_q.size() < 2);
      if (!out_vld) chk("rnd_we_idle", o_we, 0);
      if (c < 1000) begin
        drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
        out_rdy = ($urandom_range(0, 2) != 0);
      end else begin
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        out_rdy = 1'b1;
      end
      if (out_vld && out_rdy) begin
        if (sb_q.size() == 0) begin
          chk("rnd_spurious_out", out_vld, 0);
        end else begin
          exp_pkt = sb_q.pop_front();
          chk("rnd_waddr", o_waddr, exp_pkt[37:33]);
          chk("rnd_we", o_we, exp_pkt[32]);
          chk("rnd_wdata", o_wdata, exp_pkt[31:0]);
        end
      end
      if (in_vld && in_rdy) sb_q.push_back({waddr, we & (waddr != 5'd0), wdata});
      stall_prev = out_vld && !out_rdy;
      p_addr     = o_waddr;
      p_we       = o_we;
      p_data     = o_wdata;
      @(negedge clk);
    end
    chk("rnd_final_empty", sb_q.size(), 0);
    chk("rnd_final_vld", out_vld, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
